// File: rtl/traffic_sink_pkg.sv
// traffic_sink_pkg: shared NoC sizing and the sink's FSM encoding.
//   `PAYLOAD_SIZE : width of the source-id field of a packet word
//   `ADDR_BITS    : width of the destination address field
//   `NUM_NODES    : number of nodes, and so of per-source counters
// The macros stay available for older files that still use them. New code
// uses the package localparams.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef NUM_NODES
`define NUM_NODES 8
`endif

package traffic_sink_pkg;

  localparam int PAYLOAD_SIZE = `PAYLOAD_SIZE;
  localparam int ADDR_BITS    = `ADDR_BITS;
  localparam int NUM_NODES    = `NUM_NODES;
  localparam int DATA_W       = PAYLOAD_SIZE + ADDR_BITS;

  // Sink FSM. HOLD is the service window during which busy is high.
  typedef enum logic [0:0] {
    SINK_IDLE = 1'b0,
    SINK_HOLD = 1'b1
  } sink_state_e;

  // Only the low ADDR_BITS of an index are meaningful. Values at or above
  // NUM_NODES have no counter behind them.
  function automatic logic idx_in_range(input logic [ADDR_BITS-1:0] idx);
    return int'(idx) < NUM_NODES;
  endfunction

endpackage

// File: rtl/sink_count_bank.sv
// sink_count_bank: NUM_NODES saturating per-source receive counters.
//   clk      : clock
//   clear    : synchronous clear of every counter and of rd_count
//   inc_en   : increment the counter selected by inc_idx
//   inc_idx  : source index to increment (out-of-range is ignored)
//   rd_idx   : read index
//   rd_count : registered read data, one cycle after rd_idx
// A read and an increment of the same index in one cycle return the value
// from before the increment. Out-of-range reads return 0.
module sink_count_bank
  import traffic_sink_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 inc_en,
  input  logic [ADDR_BITS-1:0] inc_idx,
  input  logic [ADDR_BITS-1:0] rd_idx,
  output logic [CNT_W-1:0]     rd_count
);

  localparam int SEL_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NUM_NODES];
  logic [SEL_W-1:0] inc_sel;
  logic [SEL_W-1:0] rd_sel;

  // The range check uses the full index. Only the low bits address storage.
  assign inc_sel = inc_idx[SEL_W-1:0];
  assign rd_sel  = rd_idx[SEL_W-1:0];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        cnt[i] <= '0;
      end
      rd_count <= '0;
    end else begin
      if (inc_en && idx_in_range(inc_idx) && (cnt[inc_sel] != CNT_MAX)) begin
        cnt[inc_sel] <= cnt[inc_sel] + CNT_W'(1);
      end
      rd_count <= idx_in_range(rd_idx) ? cnt[rd_sel] : '0;
    end
  end

endmodule

// File: rtl/traffic_sink.sv
// traffic_sink: receiving end of the NoC traffic-source handshake at a
// router's local ejection port. It accepts packet words, applies a fixed
// service-time backpressure, and keeps saturating receive statistics.
//   clk, reset   : clock, synchronous active-high reset
//   data         : packet word, [ADDR_BITS-1:0] = dest, upper bits = source id
//   req          : word valid, one-cycle pulse from the network
//   busy         : registered backpressure to the network
//   rx_valid     : one-cycle pulse the cycle after an accept
//   last_src     : source id of the last accepted word
//   last_dest    : dest of the last accepted word
//   rd_src       : per-source statistics read index
//   rd_count     : per-source count for rd_src (1-cycle latency)
//   total_rx     : all accepted words
//   misroute_cnt : accepted words whose dest differs from ID
//   drop_cnt     : req pulses seen while busy
//   state_dbg    : current FSM state, for observation only
//
// Handshake: a word is offered by req=1 for one cycle. If busy is low at that
// clock edge the word is accepted. If busy is high the word is lost, and
// drop_cnt records the loss. busy is high for exactly SERVICE_CYCLES cycles
// after each accept. With SERVICE_CYCLES=0 busy never rises and words may
// arrive on every cycle.
module traffic_sink
  import traffic_sink_pkg::*;
#(
  parameter int ID             = -1,
  parameter int SERVICE_CYCLES = 2,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data,
  input  logic                    req,
  output logic                    busy,
  output logic                    rx_valid,
  output logic [PAYLOAD_SIZE-1:0] last_src,
  output logic [ADDR_BITS-1:0]    last_dest,
  input  logic [ADDR_BITS-1:0]    rd_src,
  output logic [CNT_W-1:0]        rd_count,
  output logic [CNT_W-1:0]        total_rx,
  output logic [CNT_W-1:0]        misroute_cnt,
  output logic [CNT_W-1:0]        drop_cnt,
  output sink_state_e             state_dbg
);

  localparam int SVC_W      = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
  localparam int SVC_LOAD_I = (SERVICE_CYCLES > 0) ? SERVICE_CYCLES - 1 : 0;
  localparam logic [SVC_W-1:0]     SVC_LOAD = SVC_W'(SVC_LOAD_I);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  // ID = -1 marks an anonymous sink. It does no misroute check and no logging.
  localparam bit                   ID_EN    = (ID != -1);
  localparam logic [ADDR_BITS-1:0] ID_ADDR  = ADDR_BITS'(ID);

  sink_state_e             state;
  logic [SVC_W-1:0]        svc_cnt;
  logic [PAYLOAD_SIZE-1:0] src;
  logic [ADDR_BITS-1:0]    dest;
  logic                    accept;
  logic                    drop;
  logic                    misroute;
  logic                    bank_inc;

  assign src       = data[DATA_W-1:ADDR_BITS];
  assign dest      = data[ADDR_BITS-1:0];
  assign accept    = req && (state == SINK_IDLE);
  assign drop      = req && (state == SINK_HOLD);
  assign misroute  = ID_EN && (dest != ID_ADDR);
  // Misrouted words count toward total_rx only. They never count per source.
  assign bank_inc  = accept && !misroute;
  assign state_dbg = state;

  // Service-window FSM. busy is a register that mirrors (state == SINK_HOLD).
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SINK_IDLE;
      svc_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        SINK_IDLE: begin
          if (req && (SERVICE_CYCLES > 0)) begin
            state   <= SINK_HOLD;
            svc_cnt <= SVC_LOAD;
            busy    <= 1'b1;
          end
        end
        SINK_HOLD: begin
          if (svc_cnt == '0) begin
            state <= SINK_IDLE;
            busy  <= 1'b0;
          end else begin
            svc_cnt <= svc_cnt - SVC_W'(1);
          end
        end
        default: begin
          state <= SINK_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Receive bookkeeping. Every counter saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid     <= 1'b0;
      last_src     <= '0;
      last_dest    <= '0;
      total_rx     <= '0;
      misroute_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      rx_valid <= accept;
      if (accept) begin
        last_src  <= src;
        last_dest <= dest;
        if (total_rx != CNT_MAX) begin
          total_rx <= total_rx + CNT_W'(1);
        end
        if (misroute && (misroute_cnt != CNT_MAX)) begin
          misroute_cnt <= misroute_cnt + CNT_W'(1);
        end
      end
      if (drop && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  sink_count_bank #(
    .CNT_W (CNT_W)
  ) u_bank (
    .clk      (clk),
    .clear    (reset),
    .inc_en   (bank_inc),
    .inc_idx  (src[ADDR_BITS-1:0]),
    .rd_idx   (rd_src),
    .rd_count (rd_count)
  );

`ifndef SYNTHESIS
  // Receive log in the same "##" CSV format the traffic source uses for
  // transmit. It prints on the edge where the counters update.
  always @(posedge clk) begin
    if (!reset && accept && ID_EN) begin
      $display("##,rx,%d,%d", src, dest);
    end
  end
`endif

endmodule

// File: doc/traffic_sink.md
Name: traffic_sink

Overview:
Receiving end of the NoC traffic-source handshake. It sits at a router's local ejection port opposite a per-node traffic source. It consumes {payload = source id, dest address} words qualified by req and throttles the network with busy. It keeps per-source receive statistics for the bench and logs every received packet in the same "##" CSV format the source uses for transmit.

Parameters:
ID, -1, node id of this sink; -1 disables logging and the misroute check.
SERVICE_CYCLES, 2, cycles busy stays high after each accept (0 = no backpressure).
CNT_W, 16, width of every statistics counter.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
data  in  `PAYLOAD_SIZE+`ADDR_BITS  packet word; [`ADDR_BITS-1:0] = dest, upper bits = source id.
req  in  1  word valid, one-cycle pulse from the network.
busy  out  1  registered backpressure to the network.
rx_valid  out  1  one-cycle pulse, cycle after an accept.
last_src  out  `PAYLOAD_SIZE  source id of the last accepted word.
last_dest  out  `ADDR_BITS  dest of the last accepted word.
rd_src  in  `ADDR_BITS  statistics read index.
rd_count  out  CNT_W  per-source count for rd_src, registered.
total_rx  out  CNT_W  all accepted words.
misroute_cnt  out  CNT_W  accepted words with dest != ID.
drop_cnt  out  CNT_W  req pulses seen while busy.

Behaviour:
- Reset: all outputs 0 and all NUM_NODES per-source counters 0. The FSM goes to IDLE. This holds mid-HOLD too: busy drops on the cycle after reset is sampled.
- FSM states are IDLE and HOLD. busy = (state == HOLD), driven from a register.
- Accept: req=1 and state=IDLE at a clk edge.
  - If SERVICE_CYCLES>0: go to HOLD and load svc_cnt = SERVICE_CYCLES-1.
  - If SERVICE_CYCLES=0: stay in IDLE, and back-to-back accepts are legal.
- In HOLD: svc_cnt decrements each cycle, and the FSM returns to IDLE on the edge where svc_cnt==0. busy is therefore high for exactly SERVICE_CYCLES cycles.
- On accept, at the same edge:
  - last_src and last_dest are registered.
  - rx_valid is 1 for the next cycle only.
  - total_rx increments.
  - If ID != -1 and dest != ID, misroute_cnt increments.
  - Otherwise, if src[`ADDR_BITS-1:0] < `NUM_NODES, the per-source counter[src] increments.
  - Misrouted words are not counted per-source.
- req=1 while busy=1: the word is dropped and drop_cnt increments. No other state changes.
- All counters saturate at 2^CNT_W-1 and never wrap.
- rd_count has 1-cycle read latency. If a read and an update of the same index happen in the same cycle, the read returns the pre-update value.
- Out-of-range rd_src (>= `NUM_NODES) returns 0.
- Simulation only: on accept with ID != -1, display "##,rx,%d,%d" with src and dest. The display appears at the same edge as the counter updates.

Decomposition:
- Shared defines file keeps the existing `PAYLOAD_SIZE, `ADDR_BITS and `NUM_NODES.
- Add the sink FSM state encodings (SINK_IDLE, SINK_HOLD) to the same file.
- One sub-module: sink_count_bank, with NUM_NODES saturating CNT_W counters, a synchronous clear, an increment enable with index, and the registered read port.

Test Plan:
1. Setup: ID=3, SERVICE_CYCLES=2, ADDR_BITS=4. Send req with src=1, dest=3 -> rx_valid 1 cycle later, last_src=1, busy high 2 cycles, total_rx=1, counter[1]=1.
2. Same config: req(src=2, dest=3), then req again 1 cycle later while busy -> second word dropped, drop_cnt=1, total_rx=1.
3. req(src=5, dest=7) -> misroute_cnt=1, total_rx=1, counter[5]=0, no rx count at 5.
4. SERVICE_CYCLES=0: req on 4 consecutive cycles from src=0 -> busy stays 0, counter[0]=4, drop_cnt=0.
5. CNT_W=2: 5 accepts from src=1 -> counter[1]=3 and total_rx=3, both saturated.
6. Reset asserted during HOLD -> next cycle busy=0, all counters 0. A req on the following cycle is accepted.
